// File: rtl/n_way_cache_controller_if.sv
// Bus bundle for the N-way cache controller: CPU access port and multi-cycle RAM port.
// The cache connects through the slave modport. The CPU/RAM environment connects through the master modport.
interface n_way_cache_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [1:0]            cpu_size;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wd;
  logic [DATA_WIDTH-1:0] cpu_rd;
  logic                  cpu_stall;
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [DATA_WIDTH-1:0] ram_rd;
  logic                  ram_ack;

  // Handshakes: a CPU access completes in a cycle where cpu_req=1 and cpu_stall=0.
  // The CPU must hold all of its cpu_* inputs stable while stalled.
  // ram_req, ram_we, ram_addr and ram_wd stay stable until a one-cycle ram_ack arrives.
  // ram_rd is sampled only in the ram_ack cycle.
  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wd, ram_rd, ram_ack,
    output cpu_rd, cpu_stall, ram_req, ram_we, ram_addr, ram_wd
  );
  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wd, ram_rd, ram_ack,
    input  cpu_rd, cpu_stall, ram_req, ram_we, ram_addr, ram_wd
  );
endinterface

// File: rtl/n_way_cache_controller.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
// Hits complete with zero latency. Misses run a WRITEBACK/REFILL engine against a multi-cycle RAM.
module n_way_cache_controller #(
  parameter int WAYS        = 4,
  parameter int SETS        = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BYTE_OFFSET = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  n_way_cache_controller_if.slave  bus,
  output logic [1:0]               o_dbg_state
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - BYTE_OFFSET;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_REFILL = 2'd2} state_t;

  state_t                r_state;
  logic [AGE_W-1:0]      r_victim;
  logic [IDX_W-1:0]      r_idx;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_ram_req;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wd;

  logic [TAG_W-1:0]      r_tags  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS];
  logic [AGE_W-1:0]      r_age   [SETS][WAYS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_off;
  logic                  w_hit;
  logic [AGE_W-1:0]      w_hit_way;
  logic [AGE_W-1:0]      w_hit_age;
  logic [AGE_W-1:0]      w_lru_way;
  logic [AGE_W-1:0]      w_inv_way;
  logic                  w_has_inv;
  logic [AGE_W-1:0]      w_victim;
  logic                  w_hit_go;
  logic                  w_miss;
  logic                  w_refill_done;
  logic [DATA_WIDTH-1:0] w_hit_word;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_tag = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx = bus.cpu_addr[BYTE_OFFSET +: IDX_W];
  assign w_off = bus.cpu_addr[1:0];

  // Descending scans leave the lowest matching index as the winner.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_lru_way = '0;
    w_inv_way = '0;
    w_has_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tags[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (r_age[w_idx][w] == AGE_W'(WAYS - 1)) w_lru_way = AGE_W'(w);
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = AGE_W'(w);
      end
    end
    w_victim = w_has_inv ? w_inv_way : w_lru_way;
  end

  assign w_hit_age     = r_age[w_idx][w_hit_way];
  assign w_hit_word    = r_data[w_idx][w_hit_way];
  assign w_hit_go      = (r_state == S_IDLE) && bus.cpu_req && w_hit;
  assign w_miss        = (r_state == S_IDLE) && bus.cpu_req && !w_hit;
  assign w_refill_done = (r_state == S_REFILL) && r_ram_req && bus.ram_ack;

  always_comb begin
    w_load  = w_hit_word;
    w_mask  = '1;
    w_wdata = bus.cpu_wd;
    case (bus.cpu_size)
      2'b01: begin
        w_load  = {16'b0, (w_off[1] ? w_hit_word[31:16] : w_hit_word[15:0])};
        w_mask  = w_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wdata = {2{bus.cpu_wd[15:0]}};
      end
      2'b10: begin
        w_load  = {24'b0, w_hit_word[{w_off, 3'b000} +: 8]};
        w_mask  = 32'h0000_00FF << {w_off, 3'b000};
        w_wdata = {4{bus.cpu_wd[7:0]}};
      end
      default: ;
    endcase
    w_merged = (w_hit_word & ~w_mask) | (w_wdata & w_mask);
  end

  // Stall is forced low while rst is held, so an aborted miss releases the CPU immediately.
  assign bus.cpu_stall = !rst && ((r_state != S_IDLE) || w_miss);
  assign bus.cpu_rd    = w_hit_go ? w_load : '0;
  assign bus.ram_req   = r_ram_req;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wd    = r_ram_wd;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      if (w_hit_go) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == w_hit_way) r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_hit_age) r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
        end
        if (bus.cpu_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_refill_done) begin
        r_valid[r_idx][r_victim] <= 1'b1;
        r_dirty[r_idx][r_victim] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hit_go && bus.cpu_we) r_data[w_idx][w_hit_way] <= w_merged;
    if (w_refill_done) begin
      r_data[r_idx][r_victim] <= bus.ram_rd;
      r_tags[r_idx][r_victim] <= r_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_victim   <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_ram_req  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_wd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_victim  <= w_victim;
            r_idx     <= w_idx;
            r_tag     <= w_tag;
            r_ram_req <= 1'b1;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_state    <= S_WB;
              r_ram_we   <= 1'b1;
              r_ram_addr <= {r_tags[w_idx][w_victim], w_idx, {BYTE_OFFSET{1'b0}}};
              r_ram_wd   <= r_data[w_idx][w_victim];
            end else begin
              r_state    <= S_REFILL;
              r_ram_we   <= 1'b0;
              r_ram_addr <= {w_tag, w_idx, {BYTE_OFFSET{1'b0}}};
            end
          end
        end
        S_WB: begin
          if (bus.ram_ack) begin
            r_state    <= S_REFILL;
            r_ram_req  <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= {r_tag, r_idx, {BYTE_OFFSET{1'b0}}};
          end
        end
        S_REFILL: begin
          if (!r_ram_req) begin
            r_ram_req <= 1'b1;
          end else if (bus.ram_ack) begin
            r_ram_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n_way_cache_controller.sv
// Directed bench for n_way_cache_controller (WAYS=4, SETS=4): hit vector table plus miss/evict/reset sequences.
module tb_n_way_cache_controller;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_WB = 2'd1, ST_REFILL = 2'd2;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  vec_t       vecs[14];

  n_way_cache_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  n_way_cache_controller #(
    .WAYS(4), .SETS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BYTE_OFFSET(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_size = size;
    bus.cpu_addr = addr;
    bus.cpu_wd   = wd;
  endtask

  // All sequence tasks start on a falling edge and return on a later falling edge.
  task automatic do_hit(input string name, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    set_cpu(we, size, addr, wd);
    #1;
    check({name, "_stall"}, 32'(bus.cpu_stall), 32'd0);
    if (!we) check({name, "_rd"}, bus.cpu_rd, exp_rd);
    @(negedge clk);
  endtask

  task automatic do_miss(input string name, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd);
    set_cpu(we, size, addr, wd);
    #1;
    check({name, "_miss_stall"}, 32'(bus.cpu_stall), 32'd1);
    check({name, "_miss_state"}, 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
  endtask

  // Plays the RAM: waits (bounded) for ram_req, checks the request, and acks on the hold-th cycle.
  task automatic ram_serve(input string name, input logic exp_we, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wd, input logic [31:0] rd, input int hold);
    int n = 0;
    #1;
    while (!bus.ram_req && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_req_seen"}, 32'(bus.ram_req), 32'd1);
    check({name, "_we"}, 32'(bus.ram_we), 32'(exp_we));
    check({name, "_addr"}, bus.ram_addr, exp_addr);
    check({name, "_state"}, 32'(dbg_state), exp_we ? 32'(ST_WB) : 32'(ST_REFILL));
    if (exp_we) check({name, "_wd"}, bus.ram_wd, exp_wd);
    for (int c = 1; c <= hold; c++) begin
      check({name, "_req_held"}, 32'(bus.ram_req), 32'd1);
      check({name, "_stall_held"}, 32'(bus.cpu_stall), 32'd1);
      if (c == hold) begin
        bus.ram_ack = 1'b1;
        bus.ram_rd  = rd;
      end
      @(negedge clk);
      bus.ram_ack = 1'b0;
      bus.ram_rd  = 32'h0;
      if (c != hold) #1;
    end
  endtask

  task automatic load_fill(input string name, input logic [31:0] addr, input logic [31:0] rd,
                           input int hold);
    do_miss(name, 1'b0, 2'b00, addr, 32'h0);
    ram_serve(name, 1'b0, addr, 32'h0, rd, hold);
    do_hit({name, "_done"}, 1'b0, 2'b00, addr, 32'h0, rd);
  endtask

  initial begin
    vecs[0]  = '{"rpt_load",    1'b0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{"st_b_11",     1'b1, 2'b10, 32'h11, 32'h0000_00AB, 32'h0};
    vecs[2]  = '{"ld_w_10",     1'b0, 2'b00, 32'h10, 32'h0,        32'hDEADABEF};
    vecs[3]  = '{"ld_h_12",     1'b0, 2'b01, 32'h12, 32'h0,        32'h0000DEAD};
    vecs[4]  = '{"ld_b_13",     1'b0, 2'b10, 32'h13, 32'h0,        32'h000000DE};
    vecs[5]  = '{"ld_h_10",     1'b0, 2'b01, 32'h10, 32'h0,        32'h0000ABEF};
    vecs[6]  = '{"ld_b_11",     1'b0, 2'b10, 32'h11, 32'h0,        32'h000000AB};
    vecs[7]  = '{"ld_sz3_10",   1'b0, 2'b11, 32'h10, 32'h0,        32'hDEADABEF};
    vecs[8]  = '{"st_h_13",     1'b1, 2'b01, 32'h13, 32'hFFFF5555, 32'h0};
    vecs[9]  = '{"ld_w_after_h",1'b0, 2'b00, 32'h10, 32'h0,        32'h5555ABEF};
    vecs[10] = '{"st_b_12",     1'b1, 2'b10, 32'h12, 32'hFFFFFF77, 32'h0};
    vecs[11] = '{"ld_w_after_b",1'b0, 2'b00, 32'h10, 32'h0,        32'h5577ABEF};
    vecs[12] = '{"st_w_10",     1'b1, 2'b00, 32'h10, 32'h12345678, 32'h0};
    vecs[13] = '{"ld_w_after_w",1'b0, 2'b00, 32'h10, 32'h0,        32'h12345678};

    // Clock/reset
    rst          = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_size = 2'b00;
    bus.cpu_addr = 32'h0;
    bus.cpu_wd   = 32'h0;
    bus.ram_rd   = 32'h0;
    bus.ram_ack  = 1'b0;
    #1;
    check("rst_stall",    32'(bus.cpu_stall), 32'd0);
    check("rst_rd",       bus.cpu_rd, 32'h0);
    check("rst_ram_req",  32'(bus.ram_req), 32'd0);
    check("rst_ram_we",   32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_ram_wd",   bus.ram_wd, 32'h0);
    check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_noreq_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);

    // Cold miss on 0x10 with a three-cycle RAM, then hit
    load_fill("cold_10", 32'h10, 32'hDEADBEEF, 3);

    // Lane merge/extract vectors, applied back-to-back in the same set
    for (int i = 0; i < 14; i++)
      do_hit(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // Fill the remaining ways of set 0, then make 0x00 most recent
    load_fill("fill_00", 32'h00, 32'h0A0A0A0A, 3);
    load_fill("fill_20", 32'h20, 32'h20202020, 1);
    load_fill("fill_30", 32'h30, 32'h30303030, 2);
    do_hit("touch_00", 1'b0, 2'b00, 32'h00, 32'h0, 32'h0A0A0A0A);

    // 0x10 is oldest and dirty: write-back, one idle RAM cycle, then refill of 0x40
    do_miss("evict_40", 1'b0, 2'b00, 32'h40, 32'h0);
    ram_serve("wb_10", 1'b1, 32'h10, 32'h12345678, 32'h0, 2);
    #1;
    check("wb_drop_req",   32'(bus.ram_req), 32'd0);
    check("wb_drop_state", 32'(dbg_state), 32'(ST_REFILL));
    check("wb_drop_stall", 32'(bus.cpu_stall), 32'd1);
    @(negedge clk);
    ram_serve("refill_40", 1'b0, 32'h40, 32'h0, 32'h40404040, 3);
    do_hit("hit_40",       1'b0, 2'b00, 32'h40, 32'h0, 32'h40404040);
    do_hit("still_hit_00", 1'b0, 2'b00, 32'h00, 32'h0, 32'h0A0A0A0A);
    do_hit("hit_20",       1'b0, 2'b00, 32'h20, 32'h0, 32'h20202020);
    do_hit("hit_30",       1'b0, 2'b00, 32'h30, 32'h0, 32'h30303030);

    // 0x40 is now oldest; it was refilled clean, so no write-back precedes its eviction
    load_fill("clean_evict_50", 32'h50, 32'h50505050, 1);

    // Reset while a refill is in flight
    do_miss("rst_mid", 1'b0, 2'b00, 32'h60, 32'h0);
    #1;
    check("rst_mid_req_before", 32'(bus.ram_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_req",   32'(bus.ram_req), 32'd0);
    check("rst_mid_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    do_miss("after_rst_50", 1'b0, 2'b00, 32'h50, 32'h0);
    ram_serve("after_rst_50", 1'b0, 32'h50, 32'h0, 32'h00000077, 2);
    do_hit("after_rst_50_hit", 1'b0, 2'b00, 32'h50, 32'h0, 32'h00000077);

    // Stray ack while idle
    bus.cpu_req = 1'b0;
    bus.ram_ack = 1'b1;
    bus.ram_rd  = 32'hBAD0BAD0;
    #1;
    check("stray_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    bus.ram_ack = 1'b0;
    bus.ram_rd  = 32'h0;
    #1;
    check("stray_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stray_req",   32'(bus.ram_req), 32'd0);
    @(negedge clk);
    do_hit("stray_hit_w", 1'b0, 2'b00, 32'h50, 32'h0, 32'h00000077);
    do_hit("stray_hit_b", 1'b0, 2'b10, 32'h50, 32'h0, 32'h00000077);
    do_hit("stray_hit_h", 1'b0, 2'b01, 32'h52, 32'h0, 32'h00000000);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/n_way_cache_controller.md
Name: n_way_cache_controller

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the memory stage and data RAM.
- Successor to the combinational two-way controller. Adds:
  - configurable ways and sets;
  - true-LRU age tracking;
  - byte/half/word access;
  - a sequential miss engine with a request/acknowledge handshake to a multi-cycle RAM.
- Tag, data, valid, dirty and age storage are internal flop arrays.

Parameters:
- WAYS, 4, associativity; power of two, ≥2.
- SETS, 256, number of sets; power of two.
- DATA_WIDTH, 32, word width; fixed 32 for byte/half lane logic.
- ADDR_WIDTH, 32, byte address width.
- BYTE_OFFSET, 2, log2 bytes per word.
- Derived: IDX_W=log2(SETS), TAG_W=ADDR_WIDTH-IDX_W-BYTE_OFFSET, AGE_W=log2(WAYS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  access request this cycle.
- cpu_we  in  1  1=store, 0=load.
- cpu_size  in  2  00=word, 01=half, 10=byte; 11 treated as word.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wd  in  DATA_WIDTH  store data, LSB-aligned.
- cpu_rd  out  DATA_WIDTH  load data, zero-extended; valid when cpu_req && !cpu_stall.
- cpu_stall  out  1  high while the request cannot complete this cycle.
- ram_req  out  1  RAM transaction request; held until ram_ack.
- ram_we  out  1  1=write-back, 0=refill read.
- ram_addr  out  ADDR_WIDTH  word-aligned address, low BYTE_OFFSET bits zero.
- ram_wd  out  DATA_WIDTH  victim word for write-back.
- ram_rd  in  DATA_WIDTH  refill data; valid with ram_ack.
- ram_ack  in  1  one-cycle completion pulse.

Behaviour:

Address split:
- tag = cpu_addr[ADDR_WIDTH-1 : IDX_W+BYTE_OFFSET]
- idx = next IDX_W bits
- off = cpu_addr[1:0]

Reset:
- All valid and dirty bits are 0.
- Age of way w is set to w in every set.
- State is IDLE.
- ram_req=0, ram_we=0, ram_addr=0, ram_wd=0.
- cpu_stall=0, cpu_rd=0.

State machine: IDLE, WRITEBACK, REFILL.
- IDLE, cpu_req=0: cpu_stall=0; no state changes.
- IDLE, hit (valid && tag match in exactly one way):
  - cpu_stall=0; cpu_rd is combinational from the hit way.
  - On the edge, a store merges data and sets dirty.
  - LRU update on the edge. Zero-latency hit.
- IDLE, miss:
  - cpu_stall=1 combinationally.
  - Victim = lowest-index invalid way; else the way with age==WAYS-1.
  - The victim index is latched.
  - Next state is WRITEBACK if the victim is valid && dirty, else REFILL.
- WRITEBACK:
  - ram_req=1, ram_we=1, ram_addr={victim tag, idx, 00}, ram_wd=victim word.
  - On ram_ack: go to REFILL, ram_req drops for one cycle.
- REFILL:
  - ram_req=1, ram_we=0, ram_addr={tag, idx, 00}.
  - On ram_ack: write ram_rd into the victim way; set tag, valid=1, dirty=0; return to IDLE.
  - Ages are not touched on refill.
- Back in IDLE, the still-asserted request hits and completes.
- Miss latency is 1 + (writeback ack cycles + 1 if dirty) + refill ack cycles + 1.

Stall and request rules:
- cpu_stall=1 in WRITEBACK and REFILL regardless of cpu_req.
- The CPU holds cpu_req/cpu_we/cpu_size/cpu_addr/cpu_wd stable while stalled.
- idx/tag are latched at the miss, so RAM addresses do not depend on the CPU holding them.

LRU update on hit way h with old age a:
- age[h] becomes 0.
- Every way with age < a increments.
- Ages stay a permutation of 0..WAYS-1.

Store merge:
- Word: whole word.
- Half: off[1] selects the lane; off[0] is ignored.
- Byte: off selects byte lane.
- Unselected bytes are preserved.

Load extract:
- Same lane selection; zero-extend to DATA_WIDTH.

Boundary cases:
- ram_ack while in IDLE: ignored.
- Multiple tag matches (illegal): the lowest index wins.
- Reset mid-miss: immediate abort to IDLE. ram_req drops asynchronously. The partial transaction is discarded and all lines are invalid.
- Same-set back-to-back hits: each sees the previous cycle's update.

Test Plan:
- After reset, load 0x0000_0010 (WAYS=4, SETS=4):
  - expect REFILL with ram_addr 0x10 and ram_req held for 3 cycles until ack with ram_rd=0xDEADBEEF;
  - the next cycle cpu_rd=0xDEADBEEF, stall=0;
  - a repeated load hits with 0 stall.
- Byte store 0xAB to 0x11 after the above:
  - load word 0x10 returns 0xDEADABEF;
  - half load 0x12 returns 0x0000DEAD;
  - byte load 0x13 returns 0x000000DE.
- Fill set 0 with tags at 0x00, 0x10, 0x20, 0x30; touch 0x00 again; load 0x40:
  - the evicted way is the one holding 0x10 (oldest);
  - refill address is 0x40;
  - 0x00 still hits.
- Dirty eviction: store 0x12345678 to 0x10, then force its eviction:
  - WRITEBACK precedes REFILL, with ram_we=1, ram_addr=0x10, ram_wd=0x12345678;
  - the refill line is clean.
- Assert rst during REFILL with ram_req high:
  - ram_req=0 and cpu_stall=0 in the same cycle;
  - a later load of the previously cached address misses.
- Stray ram_ack pulse in IDLE: no state change, and a subsequent hit still returns the correct data.
